// File: rtl/conv_column_feeder.sv
// Raster pixel stream to 3-word vertical column updates for the 3x3 convolver.
// Two line buffers hold rows r-2 and r-1; each pixel from row 2 onward emits one column.
module conv_column_feeder #(
   parameter int DATA_W   = 16,
   parameter int IMG_W    = 8,
   parameter int IMG_H    = 8,
   parameter int COL_BITS = 3,
   parameter int ROW_BITS = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic [DATA_W-1:0] col_data,
   output logic              col_valid,
   input  logic              col_ready,
   output logic              newline,
   output logic              frame_done
);

   typedef enum logic [2:0] {StFill, StAccept, StEmit0, StEmit1, StEmit2} state_t;

   state_t              state;
   logic [COL_BITS-1:0] col;
   logic [ROW_BITS-1:0] row;
   logic [DATA_W-1:0]   t1, t2;
   logic                last;
   logic [DATA_W-1:0]   lb0 [IMG_W];
   logic [DATA_W-1:0]   lb1 [IMG_W];

   logic pix_xfer, col_xfer, col_last, row_last;

   assign pix_xfer = pix_valid && pix_ready;
   assign col_xfer = col_valid && col_ready;
   assign col_last = (col == COL_BITS'(IMG_W - 1));
   assign row_last = (row == ROW_BITS'(IMG_H - 1));

   // Line buffer storage is never reset; FILL writes both rows before any read.
   always_ff @(posedge clk) begin
      if (pix_xfer) begin
         lb0[col] <= lb1[col];
         lb1[col] <= pix_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StFill;
         col        <= '0;
         row        <= '0;
         t1         <= '0;
         t2         <= '0;
         last       <= 1'b0;
         pix_ready  <= 1'b0;
         col_valid  <= 1'b0;
         col_data   <= '0;
         newline    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (pix_xfer) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         unique case (state)
            StFill: begin
               pix_ready <= 1'b1;
               if (pix_xfer && col_last && row == ROW_BITS'(1)) state <= StAccept;
            end
            StAccept: begin
               if (pix_xfer) begin
                  // Reads see pre-update buffer contents: rows r-2 and r-1 at this column.
                  col_data  <= lb0[col];
                  t1        <= lb1[col];
                  t2        <= pix_in;
                  newline   <= (col == '0);
                  last      <= row_last && col_last;
                  pix_ready <= 1'b0;
                  col_valid <= 1'b1;
                  state     <= StEmit0;
               end
            end
            StEmit0: begin
               if (col_xfer) begin
                  col_data <= t1;
                  newline  <= 1'b0;
                  state    <= StEmit1;
               end
            end
            StEmit1: begin
               if (col_xfer) begin
                  col_data <= t2;
                  state    <= StEmit2;
               end
            end
            StEmit2: begin
               if (col_xfer) begin
                  col_valid <= 1'b0;
                  col_data  <= '0;
                  pix_ready <= 1'b1;
                  if (last) begin
                     frame_done <= 1'b1;
                     col        <= '0;
                     row        <= '0;
                     state      <= StFill;
                  end else begin
                     state <= StAccept;
                  end
               end
            end
            default: state <= StFill;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_column_feeder.sv
// Directed bench for conv_column_feeder on a 4x4 image with pixel value = raster index.
module tb_conv_column_feeder;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] pix_in;
   logic          pix_valid;
   logic          pix_ready;
   logic [DW-1:0] col_data;
   logic          col_valid;
   logic          col_ready;
   logic          newline;
   logic          frame_done;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   conv_column_feeder #(
      .DATA_W  (DW),
      .IMG_W   (4),
      .IMG_H   (4),
      .COL_BITS(2),
      .ROW_BITS(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .col_data  (col_data),
      .col_valid (col_valid),
      .col_ready (col_ready),
      .newline   (newline),
      .frame_done(frame_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pix_valid = 1'b0; pix_in = '0; col_ready = 1'b1;
      #1;
      tests_run++;
      if ({pix_ready, col_valid, newline, frame_done} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags got %b want 0000", {pix_ready, col_valid, newline, frame_done});
      end
      tests_run++;
      if (col_data !== '0) begin
         tests_failed++; $display("FAIL reset_data got %0h want 0", col_data);
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (pix_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_release_ready got %b want 1", pix_ready);
      end
   endtask

   // Streams one frame 0..15 with pix_valid held high; columns checked word by word.
   // stall_pix: pixel whose word 1 is held off for 5 cycles; rst_pix: pixel whose word 1 is cut by reset.
   task automatic drive_frame(input int stall_pix, input int rst_pix);
      int       wait_cnt;
      logic [DW-1:0] w [3];
      for (int p = 0; p < 16; p++) begin
         pix_in = DW'(p); pix_valid = 1'b1;
         wait_cnt = 0;
         while (pix_ready !== 1'b1 && wait_cnt < 20) begin
            tick(); wait_cnt++;
         end
         tests_run++;
         if (wait_cnt >= 20) begin
            tests_failed++; $display("FAIL ready_timeout pixel %0d got ready=%b want 1", p, pix_ready);
            pix_valid = 1'b0;
            return;
         end
         tick();
         if (p < 8) begin
            tests_run++;
            if (col_valid !== 1'b0 || pix_ready !== 1'b1) begin
               tests_failed++;
               $display("FAIL fill pixel %0d got valid=%b ready=%b want 0 1", p, col_valid, pix_ready);
            end
            continue;
         end
         w[0] = DW'(p - 8); w[1] = DW'(p - 4); w[2] = DW'(p);
         tests_run++;
         if (col_valid !== 1'b1 || col_data !== w[0] || newline !== (p % 4 == 0)
             || pix_ready !== 1'b0 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL word0 pixel %0d got v=%b d=%0d nl=%b rdy=%b fd=%b want 1 %0d %b 0 0",
                     p, col_valid, col_data, newline, pix_ready, frame_done, w[0], p % 4 == 0);
         end
         tick();
         if (p == rst_pix) begin
            rst_n = 1'b0; pix_valid = 1'b0;
            #1;
            tests_run++;
            if ({pix_ready, col_valid, newline, frame_done} !== 4'b0000 || col_data !== '0) begin
               tests_failed++;
               $display("FAIL midreset got rdy=%b v=%b nl=%b fd=%b d=%0h want 0 0 0 0 0",
                        pix_ready, col_valid, newline, frame_done, col_data);
            end
            tick(); tick();
            rst_n = 1'b1;
            return;
         end
         if (p == stall_pix) begin
            col_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tests_run++;
               if (col_valid !== 1'b1 || col_data !== w[1] || pix_ready !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL stall cycle %0d got v=%b d=%0d rdy=%b want 1 %0d 0",
                           s, col_valid, col_data, pix_ready, w[1]);
               end
               tick();
            end
            col_ready = 1'b1;
         end
         for (int k = 1; k < 3; k++) begin
            tests_run++;
            if (col_valid !== 1'b1 || col_data !== w[k] || newline !== 1'b0 || pix_ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL word%0d pixel %0d got v=%b d=%0d nl=%b rdy=%b want 1 %0d 0 0",
                        k, p, col_valid, col_data, newline, pix_ready, w[k]);
            end
            if (k == 1) tick();
         end
         // Next pixel is presented while word 2 is transferred; it must wait for ACCEPT.
         if (p < 15) pix_in = DW'(p + 1);
      end
      pix_valid = 1'b0;
      tick();
      tests_run++;
      if (frame_done !== 1'b1 || col_valid !== 1'b0 || pix_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL frame_done_pulse got fd=%b v=%b rdy=%b want 1 0 1", frame_done, col_valid, pix_ready);
      end
      tick();
      tests_run++;
      if (frame_done !== 1'b0) begin
         tests_failed++; $display("FAIL frame_done_width got %b want 0", frame_done);
      end
   endtask

   task automatic test_frame();
      drive_frame(-1, -1);
   endtask

   task automatic test_back_to_back();
      drive_frame(-1, -1);
   endtask

   task automatic test_stall();
      drive_frame(9, -1);
   endtask

   task automatic test_mid_reset();
      drive_frame(-1, 13);
      drive_frame(-1, -1);
   endtask

   initial begin
      test_reset();
      test_frame();
      test_back_to_back();
      test_stall();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
